prbs8_checker: RTL and testbench
================================

// Module: prbs8_checker
// PURPOSE
//   Receive-side checker for the 8-bit PRBS stream produced by the team's LFSR generator.
//   Polynomial is x^8+x^6+x^5+x^4+1.
//   Serial recurrence is b[n] = b[n-4]^b[n-5]^b[n-6]^b[n-8].
//   Self-synchronises to an unknown phase, declares lock, then counts bit errors against a free-running
//   local copy. Drops lock on burst errors. Sits at the link/loopback test endpoint, one bit per in_valid.
// PARAMETERS
//   LOCK_LEN    16   consecutive correct predictions needed to declare lock (>=1)
//   WIN_LEN     64   window length, in valid bits, used for loss-of-lock evaluation (>=2)
//   LOSS_THRESH 4    errors within one window that force loss of lock (1..WIN_LEN)
//   CNT_W       16   width of err_cnt and bit_cnt
// PORTS
//   clk        in   1      clock, all logic on rising edge
//   rst_n      in   1      asynchronous, active-low reset
//   clr        in   1      sync clear of err_cnt/bit_cnt only (lock state untouched)
//   in_valid   in   1      in_bit is a stream bit this cycle
//   in_bit     in   1      received PRBS bit, stream order = generation order
//   locked     out  1      1 = synchronised, errors being counted
//   err_pulse  out  1      1-cycle pulse, one per mismatching bit while locked
//   err_cnt    out  CNT_W  saturating count of errors while locked
//   bit_cnt    out  CNT_W  saturating count of valid bits checked while locked
// BEHAVIOUR
//   Reset (async): state=SEARCH; hist/ref=0; fill=0; match=0; window counters=0.
//     All outputs are 0 during reset.
//   Cycles with in_valid=0: nothing changes except clr, and err_pulse returns to 0.
//   pred(x) = x[8]^x[6]^x[5]^x[4], where x[1] is the newest bit.
//     A shift is x <= {new, x[1:7]}.
//   SEARCH:
//     - Every valid bit shifts into hist.
//     - While fill<8: fill++, no compare.
//     - Once fill==8, each valid bit is checked.
//       Match (in_bit==pred(hist) and hist!=0) -> match++.
//       Anything else -> match=0.
//       All-zero history never counts, so an idle/stuck-0 line cannot lock.
//     - When a match makes match==LOCK_LEN:
//       next state LOCKED, ref <= shifted hist incl. this bit, window counters cleared.
//     - locked rises on the cycle after that bit is sampled.
//   LOCKED:
//     - Each valid bit: ref <= {pred(ref), ref[1:7]}. The local copy free-runs, so one flipped bit
//       yields exactly one error.
//     - bit_cnt++ (saturating at 2^CNT_W-1).
//     - If in_bit!=pred(ref): err_pulse=1 next cycle; err_cnt++ (saturating); win_err++.
//     - win_bits++. When this bit is the WIN_LEN-th of the window, win_bits=0 and win_err=0.
//     - Loss: when win_err reaches LOSS_THRESH, next state is SEARCH.
//       locked falls next cycle; fill=0, match=0, hist=0.
//     - If loss and window end happen on the same bit, loss wins.
//   Latency: err_pulse/err_cnt/bit_cnt update 1 cycle after the sampled bit.
//   clr=1: err_cnt and bit_cnt become 0 next cycle. It takes priority over a same-cycle increment.
//     err_pulse still fires.
//   Counters do not reset on loss/re-lock; only rst_n or clr clear them.
//   Reset mid-operation: immediate return to reset values; re-lock needs 8+LOCK_LEN valid bits.
// TESTING
//   1 Generator seeded 0x01 (oldest bit=1), in_valid=1 continuous:
//       locked=1 the cycle after the 24th bit; err_cnt stays 0; bit_cnt=N-24 after N bits.
//   2 Same as 1 with in_valid toggling 1,0,1,0:
//       locked after the 24th valid bit; no counting on idle cycles.
//   3 Locked, invert bit #40 only:
//       exactly one err_pulse, err_cnt=1, locked stays 1, following bits are error-free.
//   4 Locked, invert 4 bits within one 64-bit window:
//       err_cnt=4, locked=0 the cycle after the 4th error. Clean stream: relock 24 bits later.
//   5 Constant in_bit=0 for 200 valid bits, then constant 1 for 200:
//       locked never rises, err_cnt=0.
//   6 clr mid-run, then assert rst_n=0 while locked:
//       counters 0 after clr with locked held; after reset all outputs 0 and relock per test 1.

Source files
------------

// File: rtl/prbs8_checker.sv
// prbs8_checker: self-synchronising checker for the x^8+x^6+x^5+x^4+1 PRBS stream.
// Locks after LOCK_LEN clean predictions, then counts errors against a free-running copy.
module prbs8_checker #(
    parameter int LOCK_LEN    = 16,
    parameter int WIN_LEN     = 64,
    parameter int LOSS_THRESH = 4,
    parameter int CNT_W       = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             clr,
    input  logic             in_valid,
    input  logic             in_bit,
    output logic             locked,
    output logic             err_pulse,
    output logic [CNT_W-1:0] err_cnt,
    output logic [CNT_W-1:0] bit_cnt
);
    localparam int MW = $clog2(LOCK_LEN + 1);
    localparam int BW = $clog2(WIN_LEN);
    localparam int EW = $clog2(LOSS_THRESH + 1);

    typedef enum logic {SEARCH, LOCKED} state_t;

    state_t           state_q, state_d;
    logic [7:0]       hist_q, hist_d, loc_q, loc_d, hist_sh;
    logic [3:0]       fill_q, fill_d;
    logic [MW-1:0]    match_q, match_d;
    logic [BW-1:0]    win_bits_q, win_bits_d;
    logic [EW-1:0]    win_err_q, win_err_d, win_err_inc;
    logic             err_pulse_q, err_pulse_d, mis;
    logic [CNT_W-1:0] err_cnt_q, err_cnt_d, bit_cnt_q, bit_cnt_d;

    // Bit 0 holds the newest bit x[1], bit 7 the oldest x[8].
    function automatic logic pred(input logic [7:0] x);
        return x[7] ^ x[5] ^ x[4] ^ x[3];
    endfunction

    always_comb begin
        state_d     = state_q;
        hist_d      = hist_q;
        loc_d       = loc_q;
        fill_d      = fill_q;
        match_d     = match_q;
        win_bits_d  = win_bits_q;
        win_err_d   = win_err_q;
        err_pulse_d = 1'b0;
        err_cnt_d   = err_cnt_q;
        bit_cnt_d   = bit_cnt_q;
        hist_sh     = {hist_q[6:0], in_bit};
        mis         = in_bit != pred(loc_q);
        win_err_inc = win_err_q + EW'(mis);
        if (in_valid) begin
            if (state_q == SEARCH) begin
                hist_d = hist_sh;
                if (fill_q != 4'd8) begin
                    fill_d = fill_q + 4'd1;
                end else if (in_bit == pred(hist_q) && |hist_q) begin
                    if (match_q == MW'(LOCK_LEN - 1)) begin
                        state_d    = LOCKED;
                        loc_d      = hist_sh;
                        match_d    = '0;
                        win_bits_d = '0;
                        win_err_d  = '0;
                    end else begin
                        match_d = match_q + MW'(1);
                    end
                end else begin
                    match_d = '0;
                end
            end else begin
                loc_d       = {loc_q[6:0], pred(loc_q)};
                err_pulse_d = mis;
                bit_cnt_d   = &bit_cnt_q ? bit_cnt_q : bit_cnt_q + CNT_W'(1);
                err_cnt_d   = (mis && !(&err_cnt_q)) ? err_cnt_q + CNT_W'(1) : err_cnt_q;
                // Loss is tested before window end so it wins on a shared bit.
                if (win_err_inc == EW'(LOSS_THRESH)) begin
                    state_d    = SEARCH;
                    hist_d     = '0;
                    fill_d     = '0;
                    match_d    = '0;
                    win_bits_d = '0;
                    win_err_d  = '0;
                end else if (win_bits_q == BW'(WIN_LEN - 1)) begin
                    win_bits_d = '0;
                    win_err_d  = '0;
                end else begin
                    win_bits_d = win_bits_q + BW'(1);
                    win_err_d  = win_err_inc;
                end
            end
        end
        if (clr) begin
            err_cnt_d = '0;
            bit_cnt_d = '0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= SEARCH;
            hist_q      <= '0;
            loc_q       <= '0;
            fill_q      <= '0;
            match_q     <= '0;
            win_bits_q  <= '0;
            win_err_q   <= '0;
            err_pulse_q <= 1'b0;
            err_cnt_q   <= '0;
            bit_cnt_q   <= '0;
        end else begin
            state_q     <= state_d;
            hist_q      <= hist_d;
            loc_q       <= loc_d;
            fill_q      <= fill_d;
            match_q     <= match_d;
            win_bits_q  <= win_bits_d;
            win_err_q   <= win_err_d;
            err_pulse_q <= err_pulse_d;
            err_cnt_q   <= err_cnt_d;
            bit_cnt_q   <= bit_cnt_d;
        end
    end

    assign locked    = state_q == LOCKED;
    assign err_pulse = err_pulse_q;
    assign err_cnt   = err_cnt_q;
    assign bit_cnt   = bit_cnt_q;
endmodule

// File: tb/tb_prbs8_checker.sv
// tb_prbs8_checker: directed scenarios for prbs8_checker with hand-derived lock/error timing.
module tb_prbs8_checker;
    logic        clk = 1'b0, rst_n = 1'b0, clr = 1'b0, in_valid = 1'b0, in_bit = 1'b0;
    logic        locked, err_pulse;
    logic [15:0] err_cnt, bit_cnt;
    int          checks = 0, errors = 0, nbit = 0, pulses = 0;
    logic        ever_locked = 1'b0;
    logic [7:0]  g = 8'h80;
    int          flips[$];

    prbs8_checker dut (
        .clk(clk), .rst_n(rst_n), .clr(clr), .in_valid(in_valid), .in_bit(in_bit),
        .locked(locked), .err_pulse(err_pulse), .err_cnt(err_cnt), .bit_cnt(bit_cnt)
    );

    always #5 clk = ~clk;

    task automatic cyc(input logic v, input logic b, input logic c);
        @(negedge clk);
        in_valid = v;
        in_bit   = b;
        clr      = c;
        @(posedge clk);
        #1;
        if (err_pulse) pulses++;
        if (locked) ever_locked = 1'b1;
    endtask

    // Next generator bit (state bit 7 = oldest), optionally inverted on the wire.
    task automatic vbit(input logic c);
        logic b;
        b = g[7] ^ g[5] ^ g[4] ^ g[3];
        g = {g[6:0], b};
        nbit++;
        foreach (flips[i]) if (flips[i] == nbit) b = ~b;
        cyc(1'b1, b, c);
    endtask

    task automatic run_to(input int n);
        while (nbit < n) vbit(1'b0);
    endtask

    task automatic do_reset;
        @(negedge clk);
        rst_n = 1'b0;
        in_valid = 1'b0;
        clr = 1'b0;
        g = 8'h80;
        nbit = 0;
        pulses = 0;
        ever_locked = 1'b0;
        flips.delete();
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic test_reset;
        rst_n = 1'b0;
        for (int i = 0; i < 30; i++) cyc(1'b1, 1'(i % 3), 1'b0);
        checks++;
        if ({locked, err_pulse, err_cnt, bit_cnt} !== 34'd0) begin
            errors++;
            $display("FAIL reset_outputs got %b/%b/%0d/%0d exp all 0", locked, err_pulse, err_cnt, bit_cnt);
        end
    endtask

    task automatic test_lock_continuous;
        do_reset();
        run_to(23);
        checks++;
        if (locked !== 1'b0) begin errors++; $display("FAIL cont_lock23 locked=%b exp 0", locked); end
        run_to(24);
        checks++;
        if (locked !== 1'b1) begin errors++; $display("FAIL cont_lock24 locked=%b exp 1", locked); end
        run_to(100);
        checks++;
        if (bit_cnt !== 16'd76) begin errors++; $display("FAIL cont_bit_cnt got %0d exp 76", bit_cnt); end
        checks++;
        if (err_cnt !== 16'd0 || pulses != 0) begin
            errors++;
            $display("FAIL cont_errors err_cnt=%0d pulses=%0d exp 0/0", err_cnt, pulses);
        end
    endtask

    task automatic test_lock_gapped;
        do_reset();
        for (int i = 0; i < 23; i++) begin
            vbit(1'b0);
            cyc(1'b0, 1'($urandom_range(1)), 1'b0);
        end
        checks++;
        if (locked !== 1'b0) begin errors++; $display("FAIL gap_lock23 locked=%b exp 0", locked); end
        vbit(1'b0);
        checks++;
        if (locked !== 1'b1 || bit_cnt !== 16'd0) begin
            errors++;
            $display("FAIL gap_lock24 locked=%b bit_cnt=%0d exp 1/0", locked, bit_cnt);
        end
        for (int i = 0; i < 10; i++) begin
            vbit(1'b0);
            cyc(1'b0, 1'($urandom_range(1)), 1'b0);
        end
        checks++;
        if (bit_cnt !== 16'd10 || err_cnt !== 16'd0) begin
            errors++;
            $display("FAIL gap_counts bit_cnt=%0d err_cnt=%0d exp 10/0", bit_cnt, err_cnt);
        end
    endtask

    task automatic test_single_error;
        do_reset();
        flips.push_back(40);
        run_to(40);
        checks++;
        if (err_pulse !== 1'b1 || err_cnt !== 16'd1) begin
            errors++;
            $display("FAIL single_pulse err_pulse=%b err_cnt=%0d exp 1/1", err_pulse, err_cnt);
        end
        cyc(1'b0, 1'b0, 1'b0);
        checks++;
        if (err_pulse !== 1'b0) begin errors++; $display("FAIL idle_pulse_clear err_pulse=%b exp 0", err_pulse); end
        run_to(100);
        checks++;
        if (err_cnt !== 16'd1 || pulses != 1 || locked !== 1'b1 || bit_cnt !== 16'd76) begin
            errors++;
            $display("FAIL single_after err_cnt=%0d pulses=%0d locked=%b bit_cnt=%0d exp 1/1/1/76",
                     err_cnt, pulses, locked, bit_cnt);
        end
    endtask

    task automatic test_burst_loss;
        do_reset();
        flips = '{50, 55, 60, 65};
        run_to(64);
        checks++;
        if (locked !== 1'b1 || err_cnt !== 16'd3) begin
            errors++;
            $display("FAIL burst_pre locked=%b err_cnt=%0d exp 1/3", locked, err_cnt);
        end
        run_to(65);
        checks++;
        if (locked !== 1'b0 || err_cnt !== 16'd4 || err_pulse !== 1'b1) begin
            errors++;
            $display("FAIL burst_loss locked=%b err_cnt=%0d err_pulse=%b exp 0/4/1", locked, err_cnt, err_pulse);
        end
        run_to(88);
        checks++;
        if (locked !== 1'b0) begin errors++; $display("FAIL relock_early locked=%b exp 0", locked); end
        run_to(89);
        checks++;
        if (locked !== 1'b1 || bit_cnt !== 16'd41 || err_cnt !== 16'd4) begin
            errors++;
            $display("FAIL relock locked=%b bit_cnt=%0d err_cnt=%0d exp 1/41/4", locked, bit_cnt, err_cnt);
        end
    endtask

    task automatic test_window_boundary;
        do_reset();
        flips = '{80, 85, 88, 89};
        run_to(89);
        checks++;
        if (locked !== 1'b1 || err_cnt !== 16'd4) begin
            errors++;
            $display("FAIL window_split locked=%b err_cnt=%0d exp 1/4", locked, err_cnt);
        end
        do_reset();
        flips = '{70, 75, 80, 88};
        run_to(87);
        checks++;
        if (locked !== 1'b1) begin errors++; $display("FAIL window_end_pre locked=%b exp 1", locked); end
        run_to(88);
        checks++;
        if (locked !== 1'b0 || err_cnt !== 16'd4) begin
            errors++;
            $display("FAIL loss_at_window_end locked=%b err_cnt=%0d exp 0/4", locked, err_cnt);
        end
    endtask

    task automatic test_stuck;
        do_reset();
        for (int i = 0; i < 200; i++) cyc(1'b1, 1'b0, 1'b0);
        for (int i = 0; i < 200; i++) cyc(1'b1, 1'b1, 1'b0);
        checks++;
        if (ever_locked !== 1'b0 || err_cnt !== 16'd0 || bit_cnt !== 16'd0) begin
            errors++;
            $display("FAIL stuck ever_locked=%b err_cnt=%0d bit_cnt=%0d exp 0/0/0", ever_locked, err_cnt, bit_cnt);
        end
    endtask

    task automatic test_clr_and_reset;
        do_reset();
        run_to(50);
        checks++;
        if (bit_cnt !== 16'd26) begin errors++; $display("FAIL clr_pre bit_cnt=%0d exp 26", bit_cnt); end
        flips.push_back(51);
        vbit(1'b1);
        checks++;
        if (err_pulse !== 1'b1 || err_cnt !== 16'd0 || bit_cnt !== 16'd0 || locked !== 1'b1) begin
            errors++;
            $display("FAIL clr_priority err_pulse=%b err_cnt=%0d bit_cnt=%0d locked=%b exp 1/0/0/1",
                     err_pulse, err_cnt, bit_cnt, locked);
        end
        run_to(56);
        checks++;
        if (bit_cnt !== 16'd5 || err_cnt !== 16'd0) begin
            errors++;
            $display("FAIL clr_post bit_cnt=%0d err_cnt=%0d exp 5/0", bit_cnt, err_cnt);
        end
        @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        checks++;
        if ({locked, err_pulse, err_cnt, bit_cnt} !== 34'd0) begin
            errors++;
            $display("FAIL async_reset got %b/%b/%0d/%0d exp all 0", locked, err_pulse, err_cnt, bit_cnt);
        end
        g = 8'h80;
        nbit = 0;
        flips.delete();
        @(negedge clk);
        rst_n = 1'b1;
        run_to(23);
        checks++;
        if (locked !== 1'b0) begin errors++; $display("FAIL reset_relock23 locked=%b exp 0", locked); end
        run_to(24);
        checks++;
        if (locked !== 1'b1) begin errors++; $display("FAIL reset_relock24 locked=%b exp 1", locked); end
    endtask

    initial begin
        test_reset();
        test_lock_continuous();
        test_lock_gapped();
        test_single_error();
        test_burst_loss();
        test_window_boundary();
        test_stuck();
        test_clr_and_reset();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
